// File: rtl/iq_interpolator_if.sv
// Sample and strobe bundle between a baseband source and one iq_interpolator rail.
// A sample moves on every clk edge where in_valid && in_ready; in_sample must be held while in_valid waits.
interface iq_interpolator_if #(
  parameter int NBITS = 16
);
  logic                    cic_40_pulse;
  logic signed [NBITS-1:0] in_sample;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [NBITS-1:0] out_sample;
  logic                    out_valid;
  logic                    underrun;

  modport master (
    output cic_40_pulse, in_sample, in_valid,
    input  in_ready, out_sample, out_valid, underrun
  );

  modport slave (
    input  cic_40_pulse, in_sample, in_valid,
    output in_ready, out_sample, out_valid, underrun
  );
endinterface

// File: rtl/iq_interpolator.sv
// Linear-interpolating upsampler for one I or Q rail: each output-rate pulse emits a
// point on the line from prev to cur, stepping 2^ABITS points per input sample.
module iq_interpolator #(
  parameter int NBITS = 16,
  parameter int ABITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  iq_interpolator_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int AW = NBITS + ABITS + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [NBITS-1:0] prev_q, prev_d;
  logic signed [NBITS-1:0] cur_q, cur_d;
  logic signed [NBITS-1:0] nxt_q, nxt_d;
  logic                    nxt_full_q, nxt_full_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [ABITS-1:0]        phase_q, phase_d;
  logic signed [NBITS-1:0] out_sample_q, out_sample_d;
  logic                    out_valid_q, out_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    in_ready_q, in_ready_d;

  logic                    xfer;
  logic                    seg_end;
  logic signed [NBITS:0]   diff;
  logic signed [AW-1:0]    diff_ext;
  logic signed [AW-1:0]    cur_scaled;

  assign xfer       = bus.in_valid && in_ready_q;
  assign seg_end    = bus.cic_40_pulse && (phase_q == '1);
  assign diff       = {cur_q[NBITS-1], cur_q} - {prev_q[NBITS-1], prev_q};
  assign diff_ext   = {{ABITS{diff[NBITS]}}, diff};
  // acc holds prev scaled by 2^ABITS, so the old cur becomes the next segment's start point
  assign cur_scaled = {cur_q[NBITS-1], cur_q, {ABITS{1'b0}}};

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    nxt_full_d   = nxt_full_q;
    acc_d        = acc_q;
    phase_d      = phase_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      EMPTY: begin
        if (xfer) begin
          cur_d   = bus.in_sample;
          state_d = ONE;
        end
      end
      ONE: begin
        if (xfer) begin
          prev_d  = cur_q;
          cur_d   = bus.in_sample;
          acc_d   = cur_scaled;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          nxt_d      = bus.in_sample;
          nxt_full_d = 1'b1;
        end
        if (bus.cic_40_pulse) begin
          // arithmetic shift floors; the result lies between prev and cur so the slice is lossless
          out_sample_d = acc_q[ABITS +: NBITS];
          out_valid_d  = 1'b1;
          acc_d        = acc_q + diff_ext;
          phase_d      = phase_q + 1'b1;
          if (seg_end) begin
            prev_d  = cur_q;
            phase_d = '0;
            acc_d   = cur_scaled;
            if (nxt_full_q) begin
              cur_d      = nxt_q;
              nxt_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d = !nxt_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      prev_q       <= '0;
      cur_q        <= '0;
      nxt_q        <= '0;
      nxt_full_q   <= 1'b0;
      acc_q        <= '0;
      phase_q      <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      nxt_full_q   <= nxt_full_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      underrun_q   <= underrun_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.underrun   = underrun_q;
  assign dbg_state      = state_q;

endmodule
